// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port SRAM between the MIPS data (MEM) and instruction (IF) ports.
// Default is data-first with an i-fetch starvation guard; define MEM_ARB_RR_EN for round-robin.

module mem_arb_port #(
    parameter int AW = 12
) (
    input  logic [29:0]   word_addr,
    output logic [AW-1:0] waddr,
    output logic          oor
);
    assign waddr = word_addr[AW-1:0];
    assign oor   = |word_addr[29:AW];
endmodule

module mem_arbiter #(
    parameter int AW       = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    output logic          m_en,
    output logic [3:0]    m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);
    localparam int NP = 2;
    localparam int DP = 0;
    localparam int IP = 1;

    typedef enum logic [1:0] {RD_NONE, RD_DATA, RD_INSTR} owner_t;
    typedef struct packed {
        logic       we;
        logic [3:0] be;
    } acc_t;

    acc_t [NP-1:0]         acc;
    logic [NP-1:0][29:0]   word_addr;
    logic [NP-1:0][AW-1:0] waddr;
    logic [NP-1:0]         oor;
    logic [NP-1:0]         gnt;
    logic                  sel;
    logic                  granted;
    logic                  i_wins_tie;
    owner_t                rd_owner;
    logic                  rd_oor;
    logic [3:0]            i_wait;
    logic                  last_i;
    logic                  unused_ok;

    assign acc[DP]       = '{we: d_we, be: d_be};
    assign acc[IP]       = '{we: 1'b0, be: 4'h0};
    assign word_addr[DP] = d_addr[31:2];
    assign word_addr[IP] = i_addr[31:2];
    // SRAM is word-addressed; byte offset bits carry no information here.
    assign unused_ok     = ^{d_addr[1:0], i_addr[1:0]};

    generate
        for (genvar p = 0; p < NP; p++) begin : g_port
            mem_arb_port #(.AW(AW)) u_port (
                .word_addr (word_addr[p]),
                .waddr     (waddr[p]),
                .oor       (oor[p])
            );
        end
    endgenerate

`ifdef MEM_ARB_RR_EN
    assign i_wins_tie = !last_i;
`else
    localparam logic [3:0] MAXW = 4'(MAX_WAIT);
    assign i_wins_tie = (i_wait == MAXW);
`endif

    always_comb begin
        gnt = '0;
        if (!reset) begin
            gnt[IP] = i_req && (!d_req || i_wins_tie);
            gnt[DP] = d_req && !gnt[IP];
        end
    end

    assign d_gnt   = gnt[DP];
    assign i_gnt   = gnt[IP];
    assign granted = |gnt;
    assign sel     = gnt[IP];

    // Out-of-range accesses are granted but never reach the SRAM.
    assign m_en    = granted && !oor[sel];
    assign m_we    = (m_en && acc[sel].we) ? acc[sel].be : 4'h0;
    assign m_addr  = granted ? waddr[sel] : '0;
    assign m_wdata = reset ? 32'h0 : d_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner <= RD_NONE;
            rd_oor   <= 1'b0;
            i_wait   <= 4'h0;
            last_i   <= 1'b1;
        end else begin
            if (granted && !acc[sel].we) begin
                rd_owner <= sel ? RD_INSTR : RD_DATA;
                rd_oor   <= oor[sel];
            end else begin
                rd_owner <= RD_NONE;
                rd_oor   <= 1'b0;
            end
            if (granted)
                last_i <= sel;
`ifdef MEM_ARB_RR_EN
            i_wait <= 4'h0;
`else
            if (!i_req || gnt[IP])
                i_wait <= 4'h0;
            else if (i_wait != 4'hF)
                i_wait <= i_wait + 4'd1;
`endif
        end
    end

    assign d_rvalid = (rd_owner == RD_DATA);
    assign i_rvalid = (rd_owner == RD_INSTR);
    assign d_rdata  = (d_rvalid && !rd_oor) ? m_rdata : 32'h0;
    assign i_rdata  = (i_rvalid && !rd_oor) ? m_rdata : 32'h0;

    a_one_gnt: assert property (@(posedge clk) disable iff (reset) !(d_gnt && i_gnt));
    a_last:    assert property (@(posedge clk) disable iff (reset) granted |=> (last_i == $past(sel)));

endmodule
